// File: rtl/ysyx_22050499_xbar_arbiter_if.sv
// ysyx_22050499_xbar_arbiter_if
//
// Groups every request, response and slave-side signal of the two-master
// arbiter so it travels as one port.
//
// Handshake rules shared by every valid/ready pair in this bundle:
//   A transfer happens in a cycle where valid and ready are both high at the
//   rising edge. Once raised, valid stays high with its payload stable until
//   that cycle. Ready may depend combinationally on valid. m_rvalid and
//   m_bvalid have no ready and are always accepted while a response is awaited.
//   *_req is held by the requester until its *_gnt pulse.
//
// Modports:
//   master : arbiter view (drives grants, responses and the slave-side request)
//   slave  : environment view (drives master requests and slave responses)
interface ysyx_22050499_xbar_arbiter_if;
  // IFU side
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        ifu_gnt;
  logic        ifu_done;
  logic [31:0] ifu_rdata;
  logic        ifu_err;
  // LSU side
  logic        lsu_req;
  logic        lsu_we;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_gnt;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_err;
  // Slave side
  logic        m_arvalid;
  logic [31:0] m_araddr;
  logic        m_arready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        m_awvalid;
  logic [31:0] m_awaddr;
  logic        m_awready;
  logic        m_wvalid;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wready;
  logic        m_bvalid;
  logic [3:0]  xbar_decode;

  modport master (
    input  ifu_req, ifu_addr,
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wstrb,
    input  m_arready, m_rvalid, m_rdata, m_awready, m_wready, m_bvalid,
    output ifu_gnt, ifu_done, ifu_rdata, ifu_err,
    output lsu_gnt, lsu_done, lsu_rdata, lsu_err,
    output m_arvalid, m_araddr, m_awvalid, m_awaddr,
    output m_wvalid, m_wdata, m_wstrb, xbar_decode
  );

  modport slave (
    output ifu_req, ifu_addr,
    output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wstrb,
    output m_arready, m_rvalid, m_rdata, m_awready, m_wready, m_bvalid,
    input  ifu_gnt, ifu_done, ifu_rdata, ifu_err,
    input  lsu_gnt, lsu_done, lsu_rdata, lsu_err,
    input  m_arvalid, m_araddr, m_awvalid, m_awaddr,
    input  m_wvalid, m_wdata, m_wstrb, xbar_decode
  );
endinterface

// File: rtl/ysyx_22050499_xbar_arbiter.sv
// ysyx_22050499_xbar_arbiter
//
// Two-master (IFU, LSU) arbiter and address decoder in front of the SRAM,
// UART and CLINT slaves. One transaction is in flight at a time; LSU has fixed
// priority over IFU. The granted request is latched, decoded into a one-hot
// xbar_decode select, issued on the single slave port, and the response is
// returned to the owning master with a one-cycle *_done pulse.
//
// Decode: 0x8000_0000-0x87FF_FFFF -> 0001 (SRAM)
//         0xA000_03F8-0xA000_03FF -> 0010 (UART)
//         0xA000_0048-0xA000_004F -> 0100 (CLINT)
//         anything else           -> 0000, answered locally with err=1
//
// Ports:
//   clock        : rising-edge clock
//   reset        : asynchronous, active-high
//   bus          : ysyx_22050499_xbar_arbiter_if.master (all request/response
//                  and slave-side signals)
//   dbg_state_o  : current FSM state (IDLE=0, AR=1, R=2, WR=3, B=4, DONE=5)
//
// Parameter TIMEOUT: response wait limit in cycles, only used when the macro
// ARB_TIMEOUT_EN is defined. With ARB_TIMEOUT_EN an 8-bit wait counter aborts a
// stuck transaction with err=1 and rdata=0; without it the block waits forever.
module ysyx_22050499_xbar_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                                clock,
  input  logic                                reset,
  ysyx_22050499_xbar_arbiter_if.master        bus,
  output logic [2:0]                          dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_WR   = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;          // high in the cycle right after a grant
  logic        lsu_own_q, lsu_own_d;  // 1: LSU owns the transaction
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [3:0]  decode_q, decode_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic        arvalid, awvalid, wvalid, done;
  logic        aw_fin, w_fin;
  logic        sel_lsu;
  logic [31:0] sel_addr;
  logic [3:0]  sel_dec;

`ifdef ARB_TIMEOUT_EN
  logic [7:0]  wait_q, wait_d;
`else
  logic        unused_timeout;
  assign unused_timeout = ^TIMEOUT_CNT;
`endif

  function automatic logic [3:0] decode(input logic [31:0] a);
    logic [3:0] d;
    d = 4'b0000;
    if (a[31:27] == 5'b10000)          d = 4'b0001;
    else if (a[31:3] == 29'h1400007F)  d = 4'b0010;
    else if (a[31:3] == 29'h14000009)  d = 4'b0100;
    return d;
  endfunction

  // LSU wins whenever both request in the same IDLE cycle.
  assign sel_lsu  = bus.lsu_req;
  assign sel_addr = sel_lsu ? bus.lsu_addr : bus.ifu_addr;
  assign sel_dec  = decode(sel_addr);

  always_comb begin
    state_d   = state_q;
    gnt_d     = 1'b0;
    lsu_own_d = lsu_own_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    decode_d  = decode_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    arvalid   = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    done      = 1'b0;
    aw_fin    = 1'b0;
    w_fin     = 1'b0;

    // The first cycle after leaving IDLE only carries the registered grant;
    // slave valids and the done pulse start one cycle later (gnt_q gates them).
    unique case (state_q)
      S_IDLE: begin
        if (bus.lsu_req || bus.ifu_req) begin
          gnt_d     = 1'b1;
          lsu_own_d = sel_lsu;
          we_d      = sel_lsu & bus.lsu_we;
          addr_d    = sel_addr;
          wdata_d   = bus.lsu_wdata;
          wstrb_d   = bus.lsu_wstrb;
          decode_d  = sel_dec;
          err_d     = (sel_dec == 4'b0000);
          rdata_d   = 32'd0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (sel_dec == 4'b0000)      state_d = S_DONE;
          else if (sel_lsu && bus.lsu_we) state_d = S_WR;
          else                          state_d = S_AR;
        end
      end
      S_AR: begin
        if (!gnt_q) begin
          arvalid = 1'b1;
          if (bus.m_arready) state_d = S_R;
        end
      end
      S_R: begin
        if (bus.m_rvalid) begin
          rdata_d = bus.m_rdata;
          state_d = S_DONE;
        end
      end
      S_WR: begin
        if (!gnt_q) begin
          awvalid   = ~aw_done_q;
          wvalid    = ~w_done_q;
          aw_fin    = aw_done_q | bus.m_awready;
          w_fin     = w_done_q | bus.m_wready;
          aw_done_d = aw_fin;
          w_done_d  = w_fin;
          if (aw_fin && w_fin) state_d = S_B;
        end
      end
      S_B: begin
        if (bus.m_bvalid) state_d = S_DONE;
      end
      S_DONE: begin
        if (!gnt_q) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef ARB_TIMEOUT_EN
    // A response landing in the same cycle as the limit still completes
    // normally; otherwise the transaction is abandoned.
    wait_d = 8'd0;
    if (state_q inside {S_AR, S_R, S_WR, S_B}) begin
      wait_d = wait_q + 8'd1;
      if ((wait_q == TIMEOUT_CNT) && (state_d != S_DONE)) begin
        arvalid = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        err_d   = 1'b1;
        rdata_d = 32'd0;
        state_d = S_DONE;
      end
    end
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= 1'b0;
      lsu_own_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      decode_q  <= 4'd0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      lsu_own_q <= lsu_own_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      decode_q  <= decode_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) wait_q <= 8'd0;
    else       wait_q <= wait_d;
  end
`endif

  assign bus.ifu_gnt     = gnt_q & ~lsu_own_q;
  assign bus.lsu_gnt     = gnt_q & lsu_own_q;
  assign bus.ifu_done    = done & ~lsu_own_q;
  assign bus.lsu_done    = done & lsu_own_q;
  assign bus.ifu_rdata   = bus.ifu_done ? rdata_q : 32'd0;
  assign bus.lsu_rdata   = bus.lsu_done ? rdata_q : 32'd0;
  assign bus.ifu_err     = bus.ifu_done & err_q;
  assign bus.lsu_err     = bus.lsu_done & err_q;
  assign bus.m_arvalid   = arvalid;
  assign bus.m_araddr    = arvalid ? addr_q : 32'd0;
  assign bus.m_awvalid   = awvalid;
  assign bus.m_awaddr    = awvalid ? addr_q : 32'd0;
  assign bus.m_wvalid    = wvalid;
  assign bus.m_wdata     = wvalid ? wdata_q : 32'd0;
  assign bus.m_wstrb     = wvalid ? wstrb_q : 4'd0;
  assign bus.xbar_decode = (state_q == S_IDLE) ? 4'd0 : decode_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_ysyx_22050499_xbar_arbiter.sv
`timescale 1ns/1ps
module tb_ysyx_22050499_xbar_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 8;
`else
  localparam int unsigned TB_TIMEOUT = 255;
`endif

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;

  always #5 clock = ~clock;

  ysyx_22050499_xbar_arbiter_if bus();

  ysyx_22050499_xbar_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.master),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [32:0] exp_q[$];  // {err, rdata} per transaction, in issue order

  logic [31:0] unmapped_addrs [0:6] = '{32'h9000_0000, 32'hA000_03F7, 32'hA000_0400,
                                        32'h8800_0000, 32'h7FFF_FFFC, 32'hA000_0047,
                                        32'hA000_0050};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] model_decode(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a <= 32'h87FF_FFFF) return 4'b0001;
    if (a >= 32'hA000_03F8 && a <= 32'hA000_03FF) return 4'b0010;
    if (a >= 32'hA000_0048 && a <= 32'hA000_004F) return 4'b0100;
    return 4'b0000;
  endfunction

  // Cycle of *_done counted from the cycle the request is first presented.
  function automatic int model_done_cycle(input bit mapped, input bit we,
                                          input int ar, input int r,
                                          input int aw, input int w, input int b);
    if (!mapped) return 2;
    if (!we) return 4 + ar + r;
    return 4 + ((aw > w) ? aw : w) + b;
  endfunction

  function automatic logic [31:0] pick_addr(input int kind);
    case (kind)
      0:       return 32'h8000_0000 | ($urandom & 32'h07FF_FFFC);
      1:       return 32'hA000_03F8 + 32'($urandom_range(0, 7));
      2:       return 32'hA000_0048 + 32'($urandom_range(0, 7));
      default: return unmapped_addrs[$urandom_range(0, 6)];
    endcase
  endfunction

  function automatic bit any_output_high();
    return |{bus.ifu_gnt, bus.ifu_done, bus.ifu_err, bus.ifu_rdata,
             bus.lsu_gnt, bus.lsu_done, bus.lsu_err, bus.lsu_rdata,
             bus.m_arvalid, bus.m_araddr, bus.m_awvalid, bus.m_awaddr,
             bus.m_wvalid, bus.m_wdata, bus.m_wstrb, bus.xbar_decode};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic post_ifu(input logic [31:0] a);
    bus.ifu_req  = 1'b1;
    bus.ifu_addr = a;
  endtask

  task automatic post_lsu(input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ws);
    bus.lsu_req   = 1'b1;
    bus.lsu_we    = we;
    bus.lsu_addr  = a;
    bus.lsu_wdata = wd;
    bus.lsu_wstrb = ws;
  endtask

  // Plays the slave for one transaction owned by the given master, which must
  // already be posted. Ends one cycle after the done pulse (back in IDLE).
  task automatic run_txn(input string name, input bit is_lsu, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int ar_dly, input int r_dly,
                         input int aw_dly, input int w_dly, input int b_dly,
                         input logic [31:0] slave_rdata);
    logic [3:0]  dec;
    bit          mapped;
    int          gnt_cyc, done_cyc, ar_hs, aw_hs, w_hs;
    int          ar_cnt, aw_cnt, w_cnt, cyc, hs_max;
    bit          r_given, b_given, any_valid, other_seen;
    logic [31:0] araddr_seen, awaddr_seen, wdata_seen, obs_rdata;
    logic [3:0]  wstrb_seen, dec_at_gnt, dec_at_done;
    logic        obs_err;
    logic [32:0] exp;
    dec = model_decode(addr);
    mapped = (dec != 4'b0000);
    exp_q.push_back({!mapped, (mapped && !we) ? slave_rdata : 32'd0});
    gnt_cyc = -1; done_cyc = -1; ar_hs = -1; aw_hs = -1; w_hs = -1;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; cyc = 0;
    r_given = 0; b_given = 0; any_valid = 0; other_seen = 0;
    araddr_seen = '0; awaddr_seen = '0; wdata_seen = '0; wstrb_seen = '0;
    dec_at_gnt = '0; dec_at_done = '0; obs_rdata = '0; obs_err = 1'b0;
    while (done_cyc < 0 && cyc <= 40) begin
      if (cyc > 0) step();
      // observe
      if (is_lsu ? bus.lsu_gnt : bus.ifu_gnt) begin
        if (gnt_cyc < 0) gnt_cyc = cyc;
        dec_at_gnt = bus.xbar_decode;
        if (is_lsu) bus.lsu_req = 1'b0; else bus.ifu_req = 1'b0;
      end
      if (is_lsu ? (bus.ifu_gnt || bus.ifu_done) : (bus.lsu_gnt || bus.lsu_done))
        other_seen = 1;
      if (bus.m_arvalid || bus.m_awvalid || bus.m_wvalid) any_valid = 1;
      if (is_lsu ? bus.lsu_done : bus.ifu_done) begin
        done_cyc    = cyc;
        obs_rdata   = is_lsu ? bus.lsu_rdata : bus.ifu_rdata;
        obs_err     = is_lsu ? bus.lsu_err : bus.ifu_err;
        dec_at_done = bus.xbar_decode;
      end
      // slave read side
      bus.m_arready = bus.m_arvalid && (ar_cnt >= ar_dly);
      if (bus.m_arvalid) ar_cnt++;
      bus.m_rvalid = 1'b0;
      bus.m_rdata  = $urandom;
      if (ar_hs >= 0 && !r_given && cyc >= ar_hs + 1 + r_dly) begin
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = slave_rdata;
        r_given      = 1;
      end else if (ar_hs < 0 && $urandom_range(0, 3) == 0) begin
        bus.m_rvalid = 1'b1;  // stray response outside R
      end
      if (bus.m_arvalid && bus.m_arready) begin
        ar_hs = cyc;
        araddr_seen = bus.m_araddr;
      end
      // slave write side
      bus.m_awready = bus.m_awvalid && (aw_cnt >= aw_dly);
      if (bus.m_awvalid) aw_cnt++;
      bus.m_wready = bus.m_wvalid && (w_cnt >= w_dly);
      if (bus.m_wvalid) w_cnt++;
      bus.m_bvalid = 1'b0;
      hs_max = (aw_hs > w_hs) ? aw_hs : w_hs;
      if (aw_hs >= 0 && w_hs >= 0 && !b_given && cyc >= hs_max + 1 + b_dly) begin
        bus.m_bvalid = 1'b1;
        b_given      = 1;
      end else if ((aw_hs < 0 || w_hs < 0) && $urandom_range(0, 3) == 0) begin
        bus.m_bvalid = 1'b1;  // stray acknowledge outside B
      end
      if (bus.m_awvalid && bus.m_awready) begin
        aw_hs = cyc;
        awaddr_seen = bus.m_awaddr;
      end
      if (bus.m_wvalid && bus.m_wready) begin
        w_hs = cyc;
        wdata_seen = bus.m_wdata;
        wstrb_seen = bus.m_wstrb;
      end
      cyc++;
    end
    bus.m_arready = 0; bus.m_rvalid = 0; bus.m_awready = 0;
    bus.m_wready = 0; bus.m_bvalid = 0;

    check({name, "_done_seen"}, done_cyc >= 0, 1);
    check({name, "_gnt_cycle"}, gnt_cyc, 1);
    check({name, "_done_cycle"}, done_cyc,
          model_done_cycle(mapped, we, ar_dly, r_dly, aw_dly, w_dly, b_dly));
    check({name, "_decode_gnt"}, dec_at_gnt, dec);
    check({name, "_decode_done"}, dec_at_done, dec);
    check({name, "_other_quiet"}, other_seen, 0);
    exp = exp_q.pop_front();
    check({name, "_err"}, obs_err, exp[32]);
    if (!mapped) begin
      check({name, "_no_slave_traffic"}, any_valid, 0);
    end else if (!we) begin
      check({name, "_rdata"}, obs_rdata, exp[31:0]);
      check({name, "_araddr"}, araddr_seen, addr);
      check({name, "_arvalid_cycles"}, ar_cnt, ar_dly + 1);
    end else begin
      check({name, "_awaddr"}, awaddr_seen, addr);
      check({name, "_wdata"}, wdata_seen, wdata);
      check({name, "_wstrb"}, wstrb_seen, wstrb);
      check({name, "_awvalid_cycles"}, aw_cnt, aw_dly + 1);
      check({name, "_wvalid_cycles"}, w_cnt, w_dly + 1);
    end
    step();
    check({name, "_idle_decode"}, bus.xbar_decode, 4'b0000);
    check({name, "_done_single"}, is_lsu ? bus.lsu_done : bus.ifu_done, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  bit          to_seen;
  bit          stray_done;
  bit          r_is_lsu, r_we, r_both;
  logic [31:0] r_addr, r_addr2, r_wdata, r_rdata;
  logic [3:0]  r_wstrb;

  initial begin
    bus.ifu_req = 0; bus.ifu_addr = '0;
    bus.lsu_req = 0; bus.lsu_we = 0; bus.lsu_addr = '0;
    bus.lsu_wdata = '0; bus.lsu_wstrb = '0;
    bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rdata = '0;
    bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0;

    #12;
    check("reset_outputs_zero", any_output_high(), 0);
    check("reset_state_idle", dbg_state, 3'd0);
    @(negedge clock) reset = 1'b0;
    step();

    // IFU read, immediate arready, rvalid one cycle later.
    post_ifu(32'h8000_0004);
    run_txn("ifu_read", 0, 0, 32'h8000_0004, '0, '0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF);

    // Simultaneous requests: LSU (UART read) first, then IFU.
    post_lsu(0, 32'hA000_03F8, '0, '0);
    post_ifu(32'h8000_0008);
    run_txn("contend_lsu", 1, 0, 32'hA000_03F8, '0, '0, 1, 0, 0, 0, 0, 32'h0000_0041);
    run_txn("contend_ifu", 0, 0, 32'h8000_0008, '0, '0, 0, 2, 0, 0, 0, 32'hCAFE_F00D);

    // Store with awready one cycle ahead of wready.
    post_lsu(1, 32'h8000_0010, 32'h1234_5678, 4'b0011);
    run_txn("lsu_store", 1, 1, 32'h8000_0010, 32'h1234_5678, 4'b0011, 0, 0, 0, 1, 0, '0);

    // Unmapped load and CLINT read.
    post_lsu(0, 32'h9000_0000, '0, '0);
    run_txn("lsu_unmapped", 1, 0, 32'h9000_0000, '0, '0, 0, 0, 0, 0, 0, '0);
    post_lsu(0, 32'hA000_004C, '0, '0);
    run_txn("lsu_clint", 1, 0, 32'hA000_004C, '0, '0, 2, 1, 0, 0, 0, 32'h0BAD_F00D);

    // Asynchronous reset while waiting in R.
    post_ifu(32'h8000_0020);
    step();
    bus.ifu_req = 1'b0;
    step();
    check("rst_mid_arvalid", bus.m_arvalid, 1);
    bus.m_arready = 1'b1;
    step();
    bus.m_arready = 1'b0;
    check("rst_mid_decode", bus.xbar_decode, 4'b0001);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_outputs_zero", any_output_high(), 0);
    check("rst_mid_state_idle", dbg_state, 3'd0);
    @(negedge clock) reset = 1'b0;
    step();
    stray_done = 0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = 32'h5555_AAAA;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.m_rvalid = 1'b0;
      if (bus.ifu_done || bus.lsu_done || bus.ifu_gnt || bus.lsu_gnt) stray_done = 1;
    end
    check("rst_mid_no_done", stray_done, 0);

`ifdef ARB_TIMEOUT_EN
    // Read whose slave never answers.
    to_seen = 0;
    post_ifu(32'h8000_0100);
    for (int c = 0; c < 40 && !to_seen; c++) begin
      step();
      if (bus.ifu_gnt) bus.ifu_req = 1'b0;
      bus.m_arready = bus.m_arvalid;
      if (bus.ifu_done) begin
        to_seen = 1;
        check("timeout_err", bus.ifu_err, 1);
        check("timeout_rdata", bus.ifu_rdata, 32'd0);
      end
    end
    bus.m_arready = 1'b0;
    check("timeout_done_seen", to_seen, 1);
    step();
`endif

    // Randomised transactions.
    for (int n = 0; n < 30; n++) begin
      r_is_lsu = $urandom_range(0, 1);
      r_we     = r_is_lsu && ($urandom_range(0, 1) == 1);
      r_both   = r_is_lsu && ($urandom_range(0, 2) == 0);
      r_addr   = pick_addr($urandom_range(0, 4));
      r_addr2  = pick_addr($urandom_range(0, 4));
      r_wdata  = $urandom;
      r_wstrb  = 4'($urandom_range(0, 15));
      r_rdata  = $urandom;
      if (r_is_lsu) post_lsu(r_we, r_addr, r_wdata, r_wstrb);
      else          post_ifu(r_addr);
      if (r_both) post_ifu(r_addr2);
      run_txn("rand", r_is_lsu, r_we, r_addr, r_wdata, r_wstrb,
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              r_rdata);
      if (r_both) begin
        r_rdata = $urandom;
        run_txn("rand_queued_ifu", 0, 0, r_addr2, '0, '0,
                $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0, r_rdata);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22050499_xbar_arbiter.md
# ysyx_22050499_xbar_arbiter

Two-master arbiter and address decoder that sits directly upstream of the SRAM model and the other memory-mapped slaves. It accepts one outstanding request at a time from the instruction-fetch unit (IFU) or the load/store unit (LSU), and latches it. It drives a single valid/ready slave-side port plus a one-hot `xbar_decode` select, then returns the response to the granted master. LSU has fixed priority over IFU.

## Interface
- `TIMEOUT`, default 255: cycles to wait for a slave response before aborting. Used only with `ARB_TIMEOUT_EN`.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `ifu_req` in 1: fetch request; held until `ifu_gnt`.
- `ifu_addr` in 32: fetch address.
- `ifu_gnt` out 1: one-cycle pulse when the request is latched.
- `ifu_done` out 1: one-cycle pulse; `ifu_rdata`/`ifu_err` are valid in this cycle.
- `ifu_rdata` out 32: fetched word.
- `ifu_err` out 1: unmapped address or timeout.
- `lsu_req` in 1: load/store request; held until `lsu_gnt`.
- `lsu_we` in 1: 1 = store.
- `lsu_addr` in 32: load/store address.
- `lsu_wdata` in 32: store data.
- `lsu_wstrb` in 4: store byte strobes.
- `lsu_gnt` out 1: one-cycle pulse when the request is latched.
- `lsu_done` out 1: one-cycle pulse on load data return or store acknowledge.
- `lsu_rdata` out 32: load data.
- `lsu_err` out 1: unmapped address or timeout.
- `m_arvalid` out 1, `m_araddr` out 32, `m_arready` in 1: read-address channel.
- `m_rvalid` in 1, `m_rdata` in 32: read data; always accepted, no ready.
- `m_awvalid` out 1, `m_awaddr` out 32, `m_awready` in 1: write-address channel.
- `m_wvalid` out 1, `m_wdata` out 32, `m_wstrb` out 4, `m_wready` in 1: write-data channel.
- `m_bvalid` in 1: write acknowledge; always accepted.
- `xbar_decode` out 4: one-hot slave select. 0001 = SRAM, 0010 = UART, 0100 = CLINT, 0000 = none.

## Operation
- **States:** IDLE, AR, R, WR, B, DONE.
- **IDLE:**
  - LSU wins if both masters request.
  - Selected request fields are latched and the matching `*_gnt` pulses.
  - Decode: 0x8000_0000–0x87FF_FFFF → 0001. 0xA000_03F8–0xA000_03FF → 0010. 0xA000_0048–0xA000_004F → 0100.
  - Unmapped address → DONE with err=1; no slave traffic is issued.
  - Mapped read → AR. Mapped write → WR.
- **AR:** `m_arvalid`=1 until a cycle with `m_arready`=1, then → R.
- **R:** wait for `m_rvalid`; capture `m_rdata` → DONE.
- **WR:**
  - `m_awvalid` and `m_wvalid` rise together.
  - Each drops independently after its own ready is sampled high.
  - When both have completed → B.
- **B:** wait for `m_bvalid` → DONE.
- **DONE:**
  - Owning master's `*_done`=1 with data/err for exactly one cycle; the other master sees nothing.
  - → IDLE.
- **`xbar_decode`:** holds the latched decode from the grant cycle through DONE; 0000 in IDLE.
- **Read data:** `m_rdata` is passed unshifted; sub-word alignment is the slave's job.
- **Store data:** `lsu_wstrb` is forwarded unchanged.
- **Reset** (async, any state, including mid-transaction): state → IDLE. All outputs are 0: gnt, done, err, rdata, valids, addresses, `xbar_decode`. A request in flight is dropped with no `*_done`.

## Timing
- Grant is registered: `*_gnt` is high in the cycle after the request is seen in IDLE.
- `m_*valid` is asserted in the cycle after the grant.
- **Minimum read latency:** request → done is 4 cycles (IDLE, AR with immediate `arready`, R with immediate `rvalid`, DONE).
- **Unmapped access:** request → done is 2 cycles.
- Only one transaction is in flight. New requests are considered only in IDLE, so back-to-back throughput is one transaction per (latency + 1) cycles.
- A ready or response arriving in the same cycle its valid is first raised is honoured.
- A `m_rvalid` or `m_bvalid` outside R or B is ignored.

## Configuration
- **With `ARB_TIMEOUT_EN` defined:**
  - An 8-bit wait counter clears on entry to AR or WR and counts every cycle in AR, R, WR and B.
  - When it reaches `TIMEOUT`: all valids drop, → DONE with err=1 and rdata=0.
- **Without `ARB_TIMEOUT_EN`:** no counter; the block waits indefinitely for a slave response.

## Test plan
- IFU read 0x8000_0004; slave `arready` immediate, `rvalid` one cycle later with 0xDEADBEEF → `ifu_gnt` at cycle 1, `xbar_decode`=0001, `ifu_done` with `ifu_rdata`=0xDEADBEEF at cycle 4, `ifu_err`=0.
- IFU and LSU request in the same cycle (LSU read 0xA000_03F8) → `lsu_gnt` first with `xbar_decode`=0010. After `lsu_done`, `ifu_gnt` follows in the next IDLE cycle.
- LSU store 0x8000_0010, data 0x12345678, strb 0011; `awready` one cycle before `wready` → `m_awvalid` drops first, `m_wvalid` drops one cycle later. `lsu_done` pulses once, in the cycle after `m_bvalid`.
- LSU load from 0x9000_0000 → no `m_arvalid` ever; `lsu_done`=1 and `lsu_err`=1 two cycles after the request.
- Assert `reset` asynchronously while in R → all outputs 0 immediately, state IDLE, no `*_done`.
- With `ARB_TIMEOUT_EN` and `TIMEOUT`=8, a read whose slave never raises `rvalid` → `ifu_done` with `ifu_err`=1 and `ifu_rdata`=0.
